alu_scheduler: RTL

// Shares the single combinational ALU between NUM_REQ requesters (e.g. execute stage, branch-compare unit).

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_scheduler_if.sv | 29 ++
 rtl/alu_scheduler_rr_arbiter.sv | 36 +++
 rtl/alu_scheduler.sv | 119 +++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the ALU scheduler: ALU control codes, their legality check,
// and the scheduler FSM states.
package alu_pkg;

  localparam int ALU_CTRL_W = 4;

  typedef enum logic [ALU_CTRL_W-1:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b1000,
    ALU_XOR  = 4'b0100,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SLL  = 4'b0001,
    ALU_SRL  = 4'b0101,
    ALU_SRA  = 4'b1101,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } sched_state_e;

  function automatic logic alu_op_legal(logic [ALU_CTRL_W-1:0] ctrl);
    case (ctrl)
      ALU_ADD, ALU_SUB, ALU_XOR, ALU_OR, ALU_AND,
      ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU: alu_op_legal = 1'b1;
      default:                                      alu_op_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_scheduler_if.sv
// Requester-side request/response bundle of the ALU scheduler; fields are
// flattened per requester (requester i at [i*W +: W]).
interface alu_scheduler_if #(
  parameter int NUM_REQ = 2,
  parameter int XLEN    = 32,
  parameter int CTRL_W  = 4
) ();

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*CTRL_W-1:0] req_ctrl;
  logic [NUM_REQ*XLEN-1:0]   req_op1;
  logic [NUM_REQ*XLEN-1:0]   req_op2;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [NUM_REQ-1:0]        rsp_ready;
  logic [XLEN-1:0]           rsp_data;
  logic                      rsp_err;

  modport master (
    output req_valid, req_ctrl, req_op1, req_op2, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_ctrl, req_op1, req_op2, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );

endinterface

// File: rtl/alu_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or above ptr,
// wrapping, as both a one-hot grant and an index.
module rr_arbiter #(
  parameter int  NUM_REQ = 2,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // ptr + k folded back into [0, NUM_REQ) without a divider
      sum = {1'b0, ptr} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(NUM_REQ)) sum = sum - (IDX_W+1)'(NUM_REQ);
      cand = sum[IDX_W-1:0];
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/alu_scheduler.sv
// Time-shares one combinational ALU among NUM_REQ requesters: round-robin
// grant, one op in flight, registered ALU operands and registered result.
module alu_scheduler
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int XLEN    = 32,
  parameter int CTRL_W  = ALU_CTRL_W
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_scheduler_if.slave     bus,
  output logic [CTRL_W-1:0]  alu_ctrl,
  output logic [XLEN-1:0]    alu_op1,
  output logic [XLEN-1:0]    alu_op2,
  input  logic [XLEN-1:0]    alu_result,
  output logic [31:0]        op_count
);

  localparam int IDX_W = $clog2(NUM_REQ);

  sched_state_e       state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   owner;
  logic [XLEN-1:0]    data_q;
  logic               err_q;

  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_any;
  logic               accept;
  logic               rsp_done;

  logic [CTRL_W-1:0]  sel_ctrl;
  logic [XLEN-1:0]    sel_op1;
  logic [XLEN-1:0]    sel_op2;
  logic               sel_legal;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req   (bus.req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  // one-hot grant drives the operand mux so no index arithmetic is needed
  always_comb begin
    sel_ctrl = '0;
    sel_op1  = '0;
    sel_op2  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_ctrl = bus.req_ctrl[i*CTRL_W +: CTRL_W];
        sel_op1  = bus.req_op1[i*XLEN +: XLEN];
        sel_op2  = bus.req_op2[i*XLEN +: XLEN];
      end
    end
  end

  assign sel_legal     = alu_op_legal(ALU_CTRL_W'(sel_ctrl));
  assign accept        = (state == IDLE) && grant_any;
  assign rsp_done      = (state == RESP) && bus.rsp_ready[owner];
  assign bus.req_ready = (state == IDLE) ? grant : '0;
  assign bus.rsp_data  = data_q;
  assign bus.rsp_err   = err_q;

  always_comb begin
    bus.rsp_valid = '0;
    if (state == RESP) bus.rsp_valid[owner] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
      alu_ctrl <= '0;
      alu_op1  <= '0;
      alu_op2  <= '0;
      op_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            owner  <= grant_idx;
            rr_ptr <= (grant_idx == IDX_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
            if (sel_legal) begin
              alu_ctrl <= sel_ctrl;
              alu_op1  <= sel_op1;
              alu_op2  <= sel_op2;
              state    <= EXEC;
            end else begin
              // illegal code: answer immediately, leave ALU inputs untouched
              data_q <= '0;
              err_q  <= 1'b1;
              state  <= RESP;
            end
          end
        end
        EXEC: begin
          data_q <= alu_result;
          err_q  <= 1'b0;
          state  <= RESP;
        end
        RESP: begin
          if (rsp_done) begin
            op_count <= op_count + 32'd1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
